// File: rtl/axis_frame_len_check.sv
`default_nettype none
// ============================================================================
// Module   : axis_frame_len_check
// Purpose  : AXI-Stream frame length checker. Truncates oversize frames and
//            tags short/long frames bad on tuser. Reports length per frame.
// Revision : 1.0 - initial release
// ============================================================================
module axis_frame_len_check #(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = (DATA_WIDTH / 8),
  parameter int                    ID_WIDTH             = 8,
  parameter int                    DEST_WIDTH           = 8,
  parameter int                    USER_WIDTH           = 1,
  parameter int                    LEN_WIDTH            = 16,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,

  input  logic [LEN_WIDTH-1:0]  length_min,
  input  logic [LEN_WIDTH-1:0]  length_max,

  output logic                  status_valid,
  output logic [LEN_WIDTH-1:0]  status_frame_len,
  output logic                  status_too_short,
  output logic                  status_too_long
);

  typedef enum logic [0:0] {ST_PASS = 1'b0, ST_DROP = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  min_q, min_d;
  logic [LEN_WIDTH-1:0]  max_q, max_d;
  logic                  first_q, first_d;

  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;
  logic [DEST_WIDTH-1:0] m_tdest_q, m_tdest_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  logic                  status_valid_q, status_valid_d;
  logic [LEN_WIDTH-1:0]  status_len_q, status_len_d;
  logic                  status_short_q, status_short_d;
  logic                  status_long_q, status_long_d;

  logic [LEN_WIDTH:0]    w_beat_bytes;
  logic [LEN_WIDTH:0]    w_new_cnt;
  logic [LEN_WIDTH-1:0]  w_new_sat;
  logic [LEN_WIDTH-1:0]  w_min;
  logic [LEN_WIDTH-1:0]  w_max;
  logic [KEEP_WIDTH-1:0] w_trunc_keep;
  logic [USER_WIDTH-1:0] w_bad_user;
  logic                  w_accept;
  logic                  w_overflow;

  assign s_axis_tready = (state_q == ST_DROP) || !m_tvalid_q || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // The first beat of a frame sees the live limit ports; later beats the latched copy.
  assign w_min = first_q ? length_min : min_q;
  assign w_max = first_q ? length_max : max_q;

  assign w_new_cnt  = {1'b0, cnt_q} + w_beat_bytes;
  assign w_new_sat  = w_new_cnt[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : w_new_cnt[LEN_WIDTH-1:0];
  assign w_overflow = (w_new_cnt > {1'b0, w_max});
  assign w_bad_user = (s_axis_tuser & ~USER_BAD_FRAME_MASK) |
                      (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK);

  generate
    if (KEEP_ENABLE) begin : g_keep_count
      logic [LEN_WIDTH:0] w_room;
      // Only meaningful in PASS, where the count never exceeds the max.
      assign w_room = {1'b0, w_max - cnt_q};

      always_comb begin
        w_beat_bytes = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
          w_beat_bytes = w_beat_bytes + (LEN_WIDTH+1)'(s_axis_tkeep[i]);
        end
      end

      always_comb begin
        w_trunc_keep = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
          w_trunc_keep[i] = s_axis_tkeep[i] && ((LEN_WIDTH+1)'(i) < w_room);
        end
      end
    end else begin : g_fixed_count
      assign w_beat_bytes = (LEN_WIDTH+1)'(KEEP_WIDTH);
      assign w_trunc_keep = s_axis_tkeep;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    min_d          = min_q;
    max_d          = max_q;
    first_d        = first_q;
    m_tdata_d      = m_tdata_q;
    m_tkeep_d      = m_tkeep_q;
    m_tvalid_d     = m_tvalid_q && !m_axis_tready;
    m_tlast_d      = m_tlast_q;
    m_tid_d        = m_tid_q;
    m_tdest_d      = m_tdest_q;
    m_tuser_d      = m_tuser_q;
    status_valid_d = 1'b0;
    status_len_d   = status_len_q;
    status_short_d = status_short_q;
    status_long_d  = status_long_q;

    if (w_accept) begin
      first_d = s_axis_tlast;
      if (first_q) begin
        min_d = length_min;
        max_d = length_max;
      end

      if (state_q == ST_PASS) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = s_axis_tdata;
        m_tkeep_d  = s_axis_tkeep;
        m_tlast_d  = s_axis_tlast;
        m_tid_d    = s_axis_tid;
        m_tdest_d  = s_axis_tdest;
        m_tuser_d  = s_axis_tuser;

        if (!w_overflow) begin
          cnt_d = s_axis_tlast ? '0 : w_new_sat;
          if (s_axis_tlast) begin
            status_valid_d = 1'b1;
            status_len_d   = w_new_sat;
            status_long_d  = 1'b0;
            status_short_d = (w_new_cnt < {1'b0, w_min});
            if (w_new_cnt < {1'b0, w_min}) begin
              m_tuser_d = w_bad_user;
            end
          end
        end else begin
          m_tkeep_d = w_trunc_keep;
          m_tlast_d = 1'b1;
          m_tuser_d = w_bad_user;
          if (s_axis_tlast) begin
            status_valid_d = 1'b1;
            status_len_d   = w_new_sat;
            status_short_d = 1'b0;
            status_long_d  = 1'b1;
            cnt_d          = '0;
          end else begin
            state_d = ST_DROP;
            cnt_d   = w_new_sat;
          end
        end
      end else begin
        if (s_axis_tlast) begin
          status_valid_d = 1'b1;
          status_len_d   = w_new_sat;
          status_short_d = 1'b0;
          status_long_d  = 1'b1;
          cnt_d          = '0;
          state_d        = ST_PASS;
        end else begin
          cnt_d = w_new_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_PASS;
      cnt_q          <= '0;
      min_q          <= '0;
      max_q          <= '0;
      first_q        <= 1'b1;
      m_tdata_q      <= '0;
      m_tkeep_q      <= '0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      m_tid_q        <= '0;
      m_tdest_q      <= '0;
      m_tuser_q      <= '0;
      status_valid_q <= 1'b0;
      status_len_q   <= '0;
      status_short_q <= 1'b0;
      status_long_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      min_q          <= min_d;
      max_q          <= max_d;
      first_q        <= first_d;
      m_tdata_q      <= m_tdata_d;
      m_tkeep_q      <= m_tkeep_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tlast_q      <= m_tlast_d;
      m_tid_q        <= m_tid_d;
      m_tdest_q      <= m_tdest_d;
      m_tuser_q      <= m_tuser_d;
      status_valid_q <= status_valid_d;
      status_len_q   <= status_len_d;
      status_short_q <= status_short_d;
      status_long_q  <= status_long_d;
    end
  end

  assign m_axis_tdata     = m_tdata_q;
  assign m_axis_tkeep     = m_tkeep_q;
  assign m_axis_tvalid    = m_tvalid_q;
  assign m_axis_tlast     = m_tlast_q;
  assign m_axis_tid       = m_tid_q;
  assign m_axis_tdest     = m_tdest_q;
  assign m_axis_tuser     = m_tuser_q;
  assign status_valid     = status_valid_q;
  assign status_frame_len = status_len_q;
  assign status_too_short = status_short_q;
  assign status_too_long  = status_long_q;

endmodule
`default_nettype wire
